// File: rtl/riscv_lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package riscv_lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication,
// load extraction/extension and access legality.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [31:0] shifted;

  // Decode access width, build lanes and check legality.
  // Store encodings share values with LB/LH/LW; unsigned forms are loads only.
  always_comb begin
    be_o         = '0;
    wdata_rep_o  = '0;
    rdata_ext_o  = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    shifted      = rdata_i >> {addr_i, 3'b000};
    case (funct3_i)
      F3_LB, F3_LBU: begin
        be_o        = 4'b0001 << addr_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      F3_LH, F3_LHU: begin
        be_o         = 4'b0011 << addr_i;
        wdata_rep_o  = {2{wdata_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      F3_LW: begin
        be_o         = 4'b1111;
        wdata_rep_o  = wdata_i;
        misaligned_o = |addr_i;
      end
      default: illegal_o = 1'b1;
    endcase
    if (we_i && funct3_i[2]) illegal_o = 1'b1;
    case (funct3_i)
      F3_LB:   rdata_ext_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  rdata_ext_o = {24'h0, shifted[7:0]};
      F3_LH:   rdata_ext_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  rdata_ext_o = {16'h0, shifted[15:0]};
      F3_LW:   rdata_ext_o = rdata_i;
      default: rdata_ext_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one access at a time, drives a
// req/gnt/rvalid data port and returns a single done pulse.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            lsu_we,
  input  logic [2:0]      lsu_funct3,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;
  logic            dmem_we_q;
  logic [XLEN-1:0] dmem_addr_q;
  logic [3:0]      dmem_be_q;
  logic [XLEN-1:0] dmem_wdata_q;

  logic            idle;
  logic            accept;
  logic            al_we;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata_rep;
  logic [XLEN-1:0] al_rdata_ext;
  logic            al_misaligned;
  logic            al_illegal;
  logic            acc_err;

  assign idle    = (state_q == IDLE);
  assign accept  = idle && lsu_valid;
  assign acc_err = al_misaligned || al_illegal;

  // One aligner serves both phases: live request fields while idle
  // (legality and store lanes), latched fields later (load extraction).
  assign al_we     = idle ? lsu_we            : we_q;
  assign al_funct3 = idle ? lsu_funct3        : funct3_q;
  assign al_addr   = idle ? lsu_addr[1:0]     : addr_lo_q;

  lsu_align u_align (
    .we_i         (al_we),
    .funct3_i     (al_funct3),
    .addr_i       (al_addr),
    .wdata_i      (lsu_wdata),
    .rdata_i      (dmem_rdata),
    .be_o         (al_be),
    .wdata_rep_o  (al_wdata_rep),
    .rdata_ext_o  (al_rdata_ext),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  // Next-state logic for the access sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lsu_valid)   state_d = acc_err ? DONE : REQ;
      REQ:  if (dmem_gnt)    state_d = we_q ? DONE : WAIT;
      WAIT: if (dmem_rvalid) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State, request latches and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= lsu_we;
        funct3_q  <= lsu_funct3;
        addr_lo_q <= lsu_addr[1:0];
        err_q     <= acc_err;
        if (acc_err) begin
          rdata_q <= '0;
        end else begin
          dmem_we_q    <= lsu_we;
          dmem_addr_q  <= {lsu_addr[XLEN-1:2], 2'b00};
          dmem_be_q    <= al_be;
          dmem_wdata_q <= al_wdata_rep;
        end
      end
      if (state_q == WAIT && dmem_rvalid) rdata_q <= al_rdata_ext;
    end
  end

  assign lsu_ready  = idle;
  assign lsu_done   = (state_q == DONE);
  assign lsu_err    = (state_q == DONE) && err_q;
  assign lsu_rdata  = rdata_q;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_we      (lsu_we),
    .lsu_funct3  (lsu_funct3),
    .lsu_addr    (lsu_addr),
    .lsu_wdata   (lsu_wdata),
    .lsu_done    (lsu_done),
    .lsu_rdata   (lsu_rdata),
    .lsu_err     (lsu_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
    step();
    lsu_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0;
    lsu_addr = '0; lsu_wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    step(); step();
    chk("rst_ready", lsu_ready, 1);
    chk("rst_done",  lsu_done, 0);
    chk("rst_err",   lsu_err, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_req",   dmem_req, 0);
    chk("rst_we",    dmem_we, 0);
    chk("rst_addr",  dmem_addr, 0);
    chk("rst_be",    dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    rst = 1'b0;
    step();

    // SB 0x103, immediate grant
    dmem_gnt = 1'b1;
    issue(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
    chk("sb_req",   dmem_req, 1);
    chk("sb_ready", lsu_ready, 0);
    chk("sb_we",    dmem_we, 1);
    chk("sb_addr",  dmem_addr, 32'h100);
    chk("sb_be",    dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_nodone", lsu_done, 0);
    step();
    chk("sb_done", lsu_done, 1);
    chk("sb_err",  lsu_err, 0);
    chk("sb_req_off", dmem_req, 0);
    step();
    chk("sb_done_off", lsu_done, 0);
    chk("sb_ready_back", lsu_ready, 1);

    // LH 0x202 -> sign extended
    issue(1'b0, 3'b001, 32'h202, 32'h0);
    chk("lh_req", dmem_req, 1);
    chk("lh_we",  dmem_we, 0);
    chk("lh_addr", dmem_addr, 32'h200);
    step();
    dmem_gnt = 1'b0;
    chk("lh_wait_req", dmem_req, 0);
    chk("lh_wait_done", lsu_done, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_1234;
    step();
    dmem_rvalid = 1'b0;
    chk("lh_done",  lsu_done, 1);
    chk("lh_err",   lsu_err, 0);
    chk("lh_rdata", lsu_rdata, 32'hFFFF_8001);
    step();
    chk("lh_done_off", lsu_done, 0);
    chk("lh_rdata_hold", lsu_rdata, 32'hFFFF_8001);

    // LHU 0x202 -> zero extended
    dmem_gnt = 1'b1;
    issue(1'b0, 3'b101, 32'h202, 32'h0);
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_1234;
    step();
    dmem_rvalid = 1'b0;
    chk("lhu_done",  lsu_done, 1);
    chk("lhu_rdata", lsu_rdata, 32'h0000_8001);
    step();

    // LW misaligned: error without a memory request
    issue(1'b0, 3'b010, 32'h301, 32'h0);
    chk("lw_mis_req",   dmem_req, 0);
    chk("lw_mis_done",  lsu_done, 1);
    chk("lw_mis_err",   lsu_err, 1);
    chk("lw_mis_rdata", lsu_rdata, 0);
    step();
    chk("lw_mis_done_off", lsu_done, 0);
    chk("lw_mis_req_off",  dmem_req, 0);
    chk("lw_mis_ready",    lsu_ready, 1);

    // Illegal load funct3 011
    issue(1'b0, 3'b011, 32'h400, 32'h0);
    chk("ld011_req",  dmem_req, 0);
    chk("ld011_done", lsu_done, 1);
    chk("ld011_err",  lsu_err, 1);
    step();

    // Illegal store funct3 100 (unsigned form is load-only)
    issue(1'b1, 3'b100, 32'h400, 32'h0);
    chk("st100_req", dmem_req, 0);
    chk("st100_err", lsu_err, 1);
    step();

    // SH misaligned
    issue(1'b1, 3'b001, 32'h101, 32'h0);
    chk("sh_mis_err", lsu_err, 1);
    step();

    // SW with grant withheld for five cycles
    issue(1'b1, 3'b010, 32'h404, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk("sw_stall_req",   dmem_req, 1);
      chk("sw_stall_addr",  dmem_addr, 32'h404);
      chk("sw_stall_be",    dmem_be, 4'b1111);
      chk("sw_stall_wdata", dmem_wdata, 32'hDEAD_BEEF);
      chk("sw_stall_ready", lsu_ready, 0);
      chk("sw_stall_done",  lsu_done, 0);
      if (i < 4) step();
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("sw_done",  lsu_done, 1);
    chk("sw_err",   lsu_err, 0);
    chk("sw_ready", lsu_ready, 0);
    step();
    chk("sw_ready_back", lsu_ready, 1);

    // LB 0x001 of 0x00007F00 -> 0x7F
    dmem_gnt = 1'b1;
    issue(1'b0, 3'b000, 32'h001, 32'h0);
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_7F00;
    step();
    dmem_rvalid = 1'b0;
    chk("lb_done",  lsu_done, 1);
    chk("lb_rdata", lsu_rdata, 32'h0000_007F);
    step();

    // LB 0x003 of 0x80000000 -> sign extended 0xFFFFFF80
    dmem_gnt = 1'b1;
    issue(1'b0, 3'b000, 32'h003, 32'h0);
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_0000;
    step();
    dmem_rvalid = 1'b0;
    chk("lb3_rdata", lsu_rdata, 32'hFFFF_FF80);
    step();

    // Reset while waiting for read data; late rvalid ignored
    dmem_gnt = 1'b1;
    issue(1'b0, 3'b000, 32'h001, 32'h0);
    step();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_ready", lsu_ready, 1);
    chk("rstw_req",   dmem_req, 0);
    chk("rstw_done",  lsu_done, 0);
    chk("rstw_rdata", lsu_rdata, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    chk("rstw_late_done",  lsu_done, 0);
    chk("rstw_late_rdata", lsu_rdata, 0);
    step();
    chk("rstw_late_done2", lsu_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
